// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch, waits a fixed latency, then
// returns the stored word (or a NOP with err for a bad address) on a one-cycle valid.
module imem_responder #(
   parameter int bits       = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_req,
   input  logic [bits-1:0]       Add,
   output logic                  mem_ready,
   output logic                  valid,
   output logic [bits-1:0]       Rdata,
   output logic                  err,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [bits-1:0]       ld_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [bits-1:0]  NOP_WORD = bits'(32'h0000_0013);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [bits-1:0]         addr_q;
   logic                    valid_q;
   logic [bits-1:0]         rdata_q;
   logic                    err_q;
   logic [bits-1:0]         store_q [0:DEPTH-1];

   logic                    accept;
   logic [bits-1:0]         rd_addr;
   logic [DEPTH_LOG2-1:0]   rd_idx;
   logic                    rd_bad;

   assign mem_ready = !rst && !ld_we && (state_q == IDLE || state_q == RESP);
   assign accept    = proc_req && mem_ready;

   // With LATENCY==1 the store is read on the accepting edge, straight from Add.
   assign rd_addr = (state_q == WAIT) ? addr_q : Add;
   assign rd_idx  = rd_addr[DEPTH_LOG2+1:2];
   assign rd_bad  = (|rd_addr[1:0]) || (|rd_addr[bits-1:DEPTH_LOG2+2]);

   always_ff @(posedge clk) begin
      if (ld_we) begin
         store_q[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (accept) begin
                  addr_q <= Add;
                  cnt_q  <= CNT_INIT;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                     valid_q <= 1'b1;
                     rdata_q <= rd_bad ? NOP_WORD : store_q[rd_idx];
                     err_q   <= rd_bad;
                  end else begin
                     state_q <= WAIT;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
                  rdata_q <= rd_bad ? NOP_WORD : store_q[rd_idx];
                  err_q   <= rd_bad;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign valid = valid_q;
   assign Rdata = rdata_q;
   assign err   = err_q;

   a_proc_req_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(proc_req));

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three builds (LATENCY 2, 1, 15) share clock and reset;
// fetches push expected responses to a scoreboard popped by a valid monitor.
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        req_s      [3];
   logic [31:0] add_s      [3];
   logic        ld_we_s    [3];
   logic [9:0]  ld_addr_s  [3];
   logic [31:0] ld_data_s  [3];
   logic        ready_s    [3];
   logic        valid_s    [3];
   logic [31:0] rdata_s    [3];
   logic        err_s      [3];

   typedef struct {
      int          inst;
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc;
   int          n_chk;
   int          n_err;
   logic [31:0] last_exp [3];
   logic        last_err [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      imem_responder #(
         .bits(32),
         .DEPTH_LOG2(10),
         .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 15))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .proc_req(req_s[gi]),
         .Add(add_s[gi]),
         .mem_ready(ready_s[gi]),
         .valid(valid_s[gi]),
         .Rdata(rdata_s[gi]),
         .err(err_s[gi]),
         .ld_we(ld_we_s[gi]),
         .ld_addr(ld_addr_s[gi]),
         .ld_data(ld_data_s[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Valid high in the cycle that ends at edge N+LATENCY is seen at the negedge where cyc==N+LATENCY-1.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid_s[i] !== 1'b0) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_valid", 64'(valid_s[i]), 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("resp_inst", 64'(i), 64'(e.inst));
               check_eq("resp_data", 64'(rdata_s[i]), 64'(e.data));
               check_eq("resp_err", 64'(err_s[i]), 64'(e.err));
               check_eq("resp_cycle", 64'(cyc), 64'(e.due));
               last_exp[i] = e.data;
               last_err[i] = e.err;
               $display("resp inst=%0d data=%h err=%b cycle=%0d", i, rdata_s[i], err_s[i], cyc);
            end
         end
      end
   end

   task automatic load(input int i, input logic [9:0] idx, input logic [31:0] d);
      @(negedge clk);
      ld_we_s[i] = 1'b1;
      ld_addr_s[i] = idx;
      ld_data_s[i] = d;
      #1;
      check_eq("ready_during_load", 64'(ready_s[i]), 64'd0);
      @(posedge clk);
      #1;
      ld_we_s[i] = 1'b0;
      $display("load inst=%0d mem[%0d]=%h", i, idx, d);
   endtask

   task automatic fetch(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic e, input bit keep);
      int waited;
      @(negedge clk);
      req_s[i] = 1'b1;
      add_s[i] = a;
      #1;
      waited = 0;
      while (ready_s[i] !== 1'b1 && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (ready_s[i] !== 1'b1) begin
         check_eq("accept_timeout", 64'(ready_s[i]), 64'd1);
         req_s[i] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      sb_q.push_back('{inst: i, data: d, err: e, due: cyc + lat_of(i) - 1});
      $display("fetch inst=%0d add=%h accepted at cycle %0d", i, a, cyc);
      if (!keep) req_s[i] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check_eq("drain", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      cyc = 0;
      n_chk = 0;
      n_err = 0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_s[i] = 1'b0;
         add_s[i] = '0;
         ld_we_s[i] = 1'b0;
         ld_addr_s[i] = '0;
         ld_data_s[i] = '0;
         last_exp[i] = '0;
         last_err[i] = 1'b0;
      end

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      check_eq("rst_ready", 64'(ready_s[0]), 64'd0);
      check_eq("rst_valid", 64'(valid_s[0]), 64'd0);
      check_eq("rst_rdata", 64'(rdata_s[0]), 64'd0);
      check_eq("rst_err", 64'(err_s[0]), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      check_eq("ready_after_rst", 64'(ready_s[0]), 64'd1);

      // Single fetch, LATENCY=2.
      load(0, 10'd5, 32'h00A0_0093);
      fetch(0, 32'h14, 32'h00A0_0093, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("ready_in_wait", 64'(ready_s[0]), 64'd0);
      drain();

      // Back-to-back fetches with proc_req held high.
      load(0, 10'd0, 32'h11);
      load(0, 10'd1, 32'h22);
      load(0, 10'd2, 32'h33);
      load(0, 10'd3, 32'h44);
      fetch(0, 32'h0, 32'h11, 1'b0, 1'b1);
      fetch(0, 32'h4, 32'h22, 1'b0, 1'b1);
      fetch(0, 32'h8, 32'h33, 1'b0, 1'b1);
      fetch(0, 32'hC, 32'h44, 1'b0, 1'b0);
      drain();
      check_eq("rdata_hold", 64'(rdata_s[0]), 64'(last_exp[0]));

      // Loader write colliding with the store read of the same word.
      load(0, 10'd7, 32'hAAAA);
      fetch(0, 32'h1C, 32'hAAAA, 1'b0, 1'b0);
      @(negedge clk);
      ld_we_s[0] = 1'b1;
      ld_addr_s[0] = 10'd7;
      ld_data_s[0] = 32'hBBBB;
      #1;
      check_eq("ready_ld_in_wait", 64'(ready_s[0]), 64'd0);
      @(posedge clk);
      #1;
      ld_we_s[0] = 1'b0;
      drain();
      fetch(0, 32'h1C, 32'hBBBB, 1'b0, 1'b0);
      drain();

      // Loader activity blocks acceptance even with proc_req high in IDLE.
      @(negedge clk);
      req_s[0] = 1'b1;
      add_s[0] = 32'h14;
      ld_we_s[0] = 1'b1;
      ld_addr_s[0] = 10'd20;
      ld_data_s[0] = 32'h1234;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("ready_blocked_by_ld", 64'(ready_s[0]), 64'd0);
         @(negedge clk);
      end
      req_s[0] = 1'b0;
      ld_we_s[0] = 1'b0;
      drain();

      // Bad addresses: misaligned, then beyond the store.
      fetch(0, 32'h0000_0006, NOP, 1'b1, 1'b0);
      fetch(0, 32'h0000_1000, NOP, 1'b1, 1'b0);
      drain();
      check_eq("err_hold", 64'(err_s[0]), 64'(last_err[0]));

      // Reset mid-transaction.
      load(0, 10'd9, 32'h1234_5678);
      fetch(0, 32'h24, 32'h1234_5678, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midrst_ready", 64'(ready_s[0]), 64'd0);
      check_eq("midrst_valid", 64'(valid_s[0]), 64'd0);
      check_eq("midrst_rdata", 64'(rdata_s[0]), 64'd0);
      check_eq("midrst_err", 64'(err_s[0]), 64'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_eq("ready_after_midrst", 64'(ready_s[0]), 64'd1);
      fetch(0, 32'h24, 32'h1234_5678, 1'b0, 1'b0);
      fetch(0, 32'h14, 32'h00A0_0093, 1'b0, 1'b0);
      drain();

      // LATENCY=1 build: back-to-back at one word per cycle.
      load(1, 10'd3, 32'hCAFE_0001);
      load(1, 10'd4, 32'hCAFE_0002);
      fetch(1, 32'hC, 32'hCAFE_0001, 1'b0, 1'b1);
      fetch(1, 32'h10, 32'hCAFE_0002, 1'b0, 1'b1);
      fetch(1, 32'h2, NOP, 1'b1, 1'b0);
      drain();

      // LATENCY=15 build.
      load(2, 10'd1, 32'h1515_1515);
      fetch(2, 32'h4, 32'h1515_1515, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      check_eq("ready_l15_wait", 64'(ready_s[2]), 64'd0);
      drain();
      fetch(2, 32'hFFFF_0000, NOP, 1'b1, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
